// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter with valid/ready handshakes on both sides.
// A word is accepted only in IDLE and then emitted one bit per consumed beat,
// MSB or LSB first. Define PISO_PARITY_EN to append an even-parity bit to each
// frame (WIDTH+1 bits per frame); without it, the frame is WIDTH bits.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,  // 2..32
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CntW-1:0]  cnt_q;
  logic             ser_valid_q;
  logic             ser_out_q;
  logic             ser_last_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] sreg_shift;
  logic             next_bit;
  logic             head_in;

  assign accept  = in_valid & in_ready;
  assign consume = ser_valid_q & ser_ready;

  // Output-end selection: shifted register, the bit that becomes current after
  // a shift, and the first bit of a freshly accepted word.
  always_comb begin
    sreg_shift = '0;
    next_bit   = 1'b0;
    head_in    = 1'b0;
    if (MSB_FIRST != 0) begin
      sreg_shift = {sreg_q[WIDTH-2:0], 1'b0};
      next_bit   = sreg_q[WIDTH-2];
      head_in    = in_data[WIDTH-1];
    end else begin
      sreg_shift = {1'b0, sreg_q[WIDTH-1:1]};
      next_bit   = sreg_q[1];
      head_in    = in_data[0];
    end
  end

  // FSM with registered serial outputs; everything holds while ser_ready=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      cnt_q       <= '0;
      ser_valid_q <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StShift;
            sreg_q      <= in_data;
            cnt_q       <= CntLoad;
            ser_valid_q <= 1'b1;
            ser_out_q   <= head_in;
            // WIDTH >= 2, so the first bit is never the last one.
            ser_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q    <= ^in_data;
`endif
          end
        end
        StShift: begin
          if (consume) begin
            sreg_q <= sreg_shift;
            if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
              state_q     <= StPar;
              ser_out_q   <= parity_q;
              ser_last_q  <= 1'b1;
`else
              state_q     <= StIdle;
              ser_valid_q <= 1'b0;
              ser_out_q   <= 1'b0;
              ser_last_q  <= 1'b0;
`endif
            end else begin
              cnt_q     <= cnt_q - CntOne;
              ser_out_q <= next_bit;
`ifdef PISO_PARITY_EN
              ser_last_q <= 1'b0;
`else
              // The bit about to be presented is data bit counter==0.
              ser_last_q <= (cnt_q == CntOne);
`endif
            end
          end
        end
`ifdef PISO_PARITY_EN
        StPar: begin
          if (consume) begin
            state_q     <= StIdle;
            ser_valid_q <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_last_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q     <= StIdle;
          ser_valid_q <= 1'b0;
          ser_out_q   <= 1'b0;
          ser_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign ser_valid = ser_valid_q;
  assign ser_out   = ser_out_q;
  assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance
// (WIDTH=8) share clock, reset, data and ser_ready; 'sel' picks which one is
// driven and observed. Expected bits are computed from the word under test.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int Nb = 9;
`else
  localparam int Nb = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       ser_ready = 1'b1;

  logic in_valid_m, in_ready_m, ser_valid_m, ser_out_m, ser_last_m, busy_m;
  logic in_valid_l, in_ready_l, ser_valid_l, ser_out_l, ser_last_l, busy_l;
  logic in_ready_s, ser_valid_s, ser_out_s, ser_last_s, busy_s;

  int checks = 0;
  int errors = 0;

  assign in_valid_m = in_valid & ~sel;
  assign in_valid_l = in_valid & sel;

  always_comb begin
    in_ready_s  = sel ? in_ready_l  : in_ready_m;
    ser_valid_s = sel ? ser_valid_l : ser_valid_m;
    ser_out_s   = sel ? ser_out_l   : ser_out_m;
    ser_last_s  = sel ? ser_last_l  : ser_last_m;
    busy_s      = sel ? busy_l      : busy_m;
  end

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid_m),
    .in_data  (in_data),
    .in_ready (in_ready_m),
    .ser_ready(ser_ready),
    .ser_valid(ser_valid_m),
    .ser_out  (ser_out_m),
    .ser_last (ser_last_m),
    .busy     (busy_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid_l),
    .in_data  (in_data),
    .in_ready (in_ready_l),
    .ser_ready(ser_ready),
    .ser_valid(ser_valid_l),
    .ser_out  (ser_out_l),
    .ser_last (ser_last_l),
    .busy     (busy_l)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i of a frame: data bits in wire order, then the parity bit at i==8.
  function automatic logic exp_bit(input logic [7:0] d, input int i, input logic lsb);
    if (i >= 8) return ^d;
    return lsb ? d[i] : d[7-i];
  endfunction

  task automatic check_bit(input string tag, input logic [7:0] d, input int i);
    check_eq($sformatf("%s_b%0d_valid", tag, i), 32'(ser_valid_s), 32'd1);
    check_eq($sformatf("%s_b%0d_out", tag, i), 32'(ser_out_s), 32'(exp_bit(d, i, sel)));
    check_eq($sformatf("%s_b%0d_last", tag, i), 32'(ser_last_s), 32'(i == Nb - 1));
    check_eq($sformatf("%s_b%0d_busy", tag, i), 32'(busy_s), 32'd1);
    check_eq($sformatf("%s_b%0d_inrdy", tag, i), 32'(in_ready_s), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_idle_valid"}, 32'(ser_valid_s), 32'd0);
    check_eq({tag, "_idle_out"}, 32'(ser_out_s), 32'd0);
    check_eq({tag, "_idle_last"}, 32'(ser_last_s), 32'd0);
    check_eq({tag, "_idle_inrdy"}, 32'(in_ready_s), 32'd1);
    check_eq({tag, "_idle_busy"}, 32'(busy_s), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready_s && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_wait_ready"}, 32'(in_ready_s), 32'd1);
  endtask

  // One frame; with stall set, every odd bit is held through two ser_ready=0
  // cycles while in_data is scrambled to prove it is ignored mid-frame.
  task automatic frame(input string tag, input logic [7:0] d, input bit stall);
    wait_ready(tag);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < Nb; i++) begin
      if (stall && (i % 2 == 1)) begin
        ser_ready = 1'b0;
        repeat (2) begin
          in_data = ~in_data;
          tick();
          check_bit({tag, "_hold"}, d, i);
        end
        ser_ready = 1'b1;
      end
      check_bit(tag, d, i);
      tick();
    end
    check_idle(tag);
  endtask

  initial begin
    #1;
    check_eq("rst_inrdy_m", 32'(in_ready_m), 32'd1);
    check_eq("rst_valid_m", 32'(ser_valid_m), 32'd0);
    check_eq("rst_busy_m", 32'(busy_m), 32'd0);
    check_eq("rst_inrdy_l", 32'(in_ready_l), 32'd1);
    check_eq("rst_valid_l", 32'(ser_valid_l), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    sel = 1'b0;
    frame("a5_msb", 8'hA5, 1'b0);
    frame("01_msb", 8'h01, 1'b0);
    sel = 1'b1;
    frame("a5_lsb", 8'hA5, 1'b0);
    frame("01_lsb", 8'h01, 1'b0);
    sel = 1'b0;
    frame("3c_stall", 8'h3C, 1'b1);

    // Reset mid-frame after three bits of 8'hFF.
    wait_ready("rst_ff");
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_bit("rst_ff", 8'hFF, i);
      tick();
    end
    rst = 1'b0;
    #1;
    check_eq("rst_async_valid", 32'(ser_valid_s), 32'd0);
    check_eq("rst_async_out", 32'(ser_out_s), 32'd0);
    check_eq("rst_async_busy", 32'(busy_s), 32'd0);
    check_eq("rst_async_inrdy", 32'(in_ready_s), 32'd1);
    tick();
    check_eq("rst_hold_valid", 32'(ser_valid_s), 32'd0);
    rst = 1'b1;
    frame("after_rst_81", 8'h81, 1'b0);

    // Parity-sensitive words (9th bit 1 and 0 when parity is built in).
    frame("07", 8'h07, 1'b0);
    frame("03", 8'h03, 1'b0);
    sel = 1'b1;
    frame("07_lsb", 8'h07, 1'b1);
    sel = 1'b0;

    // Back-to-back: in_valid stays high; the second word waits for IDLE.
    wait_ready("b2b");
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_data = 8'h5A;
    for (int i = 0; i < Nb; i++) begin
      check_bit("b2b1", 8'hC3, i);
      tick();
    end
    check_eq("b2b_gap_inrdy", 32'(in_ready_s), 32'd1);
    check_eq("b2b_gap_valid", 32'(ser_valid_s), 32'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < Nb; i++) begin
      check_bit("b2b2", 8'h5A, i);
      tick();
    end
    check_idle("b2b2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
